data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Controller that owns the single port of the CPU data memory and shares it between the CPU MEM stage and the debug unit. It arbitrates requests round-robin and generates word addresses and byte enables for SB/SH/SW stores. It right-aligns load data so the downstream load sign/zero-extension logic sees the addressed byte or half at bit 0. It also detects misaligned or illegal accesses and tracks the one outstanding read so that returned data is steered to the correct requester.

## Interface
- DATA_WIDTH, 32, data bus width (block supports 32 only)
- ADDR_WIDTH, 10, byte-address width; memory word address is ADDR_WIDTH-2 bits
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cpu_req / i_cpu_we  in  1 / 1  CPU request; write when we=1
- i_cpu_addr  in  ADDR_WIDTH  CPU byte address
- i_cpu_wdata  in  DATA_WIDTH  CPU store data, right-aligned
- i_cpu_func3  in  3  RISC-V func3 of the load or store
- o_cpu_gnt  out  1  CPU request accepted this cycle
- o_cpu_fault  out  1  accepted CPU request was misaligned or had an illegal func3
- o_cpu_rvalid  out  1  CPU read data valid
- o_cpu_rdata  out  DATA_WIDTH  CPU read data, right-shifted by the byte offset
- i_dbg_req / i_dbg_we  in  1 / 1  debug request; word access only
- i_dbg_lock  in  1  debug exclusive ownership; CPU is never granted while high
- i_dbg_addr  in  ADDR_WIDTH  debug byte address; bits [1:0] ignored
- i_dbg_wdata  in  DATA_WIDTH  debug store word
- o_dbg_gnt / o_dbg_rvalid  out  1 / 1  debug grant / read data valid
- o_dbg_rdata  out  DATA_WIDTH  raw memory word
- o_mem_en  out  1  memory access strobe
- o_mem_be  out  4  byte write enables; all 0 means read
- o_mem_addr  out  ADDR_WIDTH-2  word address
- o_mem_wdata  out  DATA_WIDTH  lane-replicated write data
- i_mem_rdata  in  DATA_WIDTH  synchronous RAM output, valid the cycle after o_mem_en

## Operation
- Request/grant handshake:
  - A requester holds req and its payload stable until it sees gnt.
  - gnt is combinational in the same cycle as the request.
  - A write completes in its grant cycle.
- Arbitration:
  - i_dbg_lock=1: only debug can be granted.
  - Otherwise, one requester active: grant it.
  - Otherwise, both requesting: grant the one not granted last.
  - The last-grant register updates on every grant; reset value is DBG, so the CPU wins the first tie.
- Read tracking FSM, states IDLE, RD_CPU, RD_DBG:
  - A read grant moves the FSM to RD_CPU or RD_DBG and latches the offset addr[1:0] for a CPU read.
  - The next cycle pulses the matching rvalid.
  - If a new read is granted in that same cycle, the FSM moves to that requester's RD state; otherwise it returns to IDLE.
  - Back-to-back reads at full rate are supported.
- CPU stores:
  - SB (000): be=0001<<off, wdata={4{byte}}.
  - SH (001): be=0011<<off, wdata={2{half}}.
  - SW (010): be=1111.
- CPU loads:
  - LB/LBU/LH/LHU/LW: o_cpu_rdata = i_mem_rdata >> (8*latched offset), upper bits zero-filled.
- Faults:
  - Conditions: halfword access with addr[0]=1; word access with addr[1:0]!=0; store func3 not in {000,001,010}; load func3 in {011,110,111}.
  - A faulting request is still granted, and o_cpu_fault pulses in the grant cycle.
  - o_mem_en stays 0 for a faulting request.
  - A faulting read still produces o_cpu_rvalid the next cycle, with o_cpu_rdata=0.
- Debug accesses:
  - Debug writes set be=1111 and wdata=i_dbg_wdata.
  - Debug reads return the raw word.
- When no grant occurs: o_mem_en=0, o_mem_be=0, o_mem_addr and o_mem_wdata are don't-care.

## Timing
- Reset (asynchronous, active-low):
  - FSM=IDLE, last-grant=DBG, latched offset=0.
  - o_cpu_rvalid=0 and o_dbg_rvalid=0; o_cpu_rdata=0 when rvalid=0.
  - gnt, fault and mem outputs follow their inputs combinationally, so they are 0 while no request is present.
- Latency:
  - Write: grant at cycle N, RAM updated at edge N+1.
  - Read: grant at N, rvalid and rdata at N+1.
- Reset asserted with a read pending: the rvalid is dropped and never emitted after reset release.
- i_dbg_lock rising while a CPU read is pending: the CPU rvalid is still delivered in the next cycle.
- A request withdrawn before its grant is undefined stimulus; the block does not check for it.

## Test plan
- CPU SW addr 0x010 wdata 0xDEADBEEF, then LW addr 0x010 -> write: mem_be=1111, mem_addr=0x004; read: rvalid next cycle, rdata=0xDEADBEEF.
- CPU SB addr 0x013 wdata 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5; then LBU addr 0x013 with mem word 0xA5000000 -> rdata=0x000000A5.
- CPU and debug both request reads every cycle for 6 cycles -> grants alternate CPU, DBG, CPU, ..., and each rvalid lands on the correct port one cycle after its grant.
- i_dbg_lock=1 with both requesting -> only o_dbg_gnt asserts; after dropping lock, o_cpu_gnt asserts in the same cycle.
- CPU LW addr 0x002 and SH addr 0x001 -> gnt=1, fault=1, mem_en=0; the LW returns rvalid with rdata=0 one cycle later.
- Assert i_rst_n=0 in the cycle after a debug read grant -> no o_dbg_rvalid pulse; after release, FSM=IDLE and the first tie goes to the CPU.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Owns the single data-memory port: round-robin arbitration between the CPU MEM stage
// and the debug unit, store lane/byte-enable generation, load alignment and fault detection.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  input  logic [2:0]            i_cpu_func3,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_fault,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic                  i_dbg_lock,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH-3:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_DBG} state_t;

  state_t     state_reg;
  logic       last_dbg_reg;
  logic [1:0] off_reg;
  logic       rd_fault_reg;

  logic cpu_cand, cpu_sel, dbg_sel;
  logic func_bad, misal, cpu_bad, cpu_ok;
  logic unused_dbg_addr_lsb;

  assign unused_dbg_addr_lsb = &{1'b0, i_dbg_addr[1:0]};

  // Debug wins a tie only when the CPU had the previous grant
  assign cpu_cand = i_cpu_req & ~i_dbg_lock;
  assign dbg_sel  = i_dbg_req & (~cpu_cand | ~last_dbg_reg);
  assign cpu_sel  = cpu_cand & ~dbg_sel;

  always_comb begin
    func_bad = 1'b0;
    misal    = 1'b0;
    if (i_cpu_we)
      func_bad = !(i_cpu_func3 inside {3'b000, 3'b001, 3'b010});
    else
      func_bad = i_cpu_func3 inside {3'b011, 3'b110, 3'b111};
    case (i_cpu_func3[1:0])
      2'b01:   misal = i_cpu_addr[0];
      2'b10:   misal = |i_cpu_addr[1:0];
      default: misal = 1'b0;
    endcase
  end

  assign cpu_bad = func_bad | misal;
  assign cpu_ok  = cpu_sel & ~cpu_bad;

  assign o_cpu_gnt   = cpu_sel;
  assign o_dbg_gnt   = dbg_sel;
  assign o_cpu_fault = cpu_sel & cpu_bad;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = i_cpu_addr[ADDR_WIDTH-1:2];
    o_mem_wdata = i_cpu_wdata;
    if (dbg_sel) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_dbg_addr[ADDR_WIDTH-1:2];
      o_mem_wdata = i_dbg_wdata;
      o_mem_be    = i_dbg_we ? 4'b1111 : 4'b0000;
    end else if (cpu_ok) begin
      o_mem_en = 1'b1;
      if (i_cpu_we) begin
        case (i_cpu_func3[1:0])
          2'b00: begin
            o_mem_be    = 4'b0001 << i_cpu_addr[1:0];
            o_mem_wdata = {4{i_cpu_wdata[7:0]}};
          end
          2'b01: begin
            o_mem_be    = 4'b0011 << i_cpu_addr[1:0];
            o_mem_wdata = {2{i_cpu_wdata[15:0]}};
          end
          default: o_mem_be = 4'b1111;
        endcase
      end
    end
  end

  // A read grant in the response cycle re-arms the FSM, giving full-rate reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      last_dbg_reg <= 1'b1;
      off_reg      <= 2'b00;
      rd_fault_reg <= 1'b0;
    end else begin
      if (dbg_sel || cpu_sel)
        last_dbg_reg <= dbg_sel;
      if (dbg_sel && !i_dbg_we) begin
        state_reg <= RD_DBG;
      end else if (cpu_sel && !i_cpu_we) begin
        state_reg    <= RD_CPU;
        off_reg      <= i_cpu_addr[1:0];
        rd_fault_reg <= cpu_bad;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  assign o_cpu_rvalid = (state_reg == RD_CPU);
  assign o_dbg_rvalid = (state_reg == RD_DBG);
  assign o_cpu_rdata  = (o_cpu_rvalid && !rd_fault_reg) ? (i_mem_rdata >> {off_reg, 3'b000})
                                                        : '0;
  assign o_dbg_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-enabled synchronous RAM model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [9:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [2:0]  cpu_func3;
  logic        cpu_gnt, cpu_fault, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram [0:255];
  logic        prev_cpu;
  logic [31:0] prev_data;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_func3(cpu_func3),
    .o_cpu_gnt(cpu_gnt), .o_cpu_fault(cpu_fault), .o_cpu_rvalid(cpu_rvalid),
    .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_lock(dbg_lock),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_be == 4'b0000) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [9:0] a,
                     input logic [31:0] d, input logic [2:0] f3);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_func3 = f3;
  endtask

  task automatic dbg(input logic req, input logic we, input logic lock,
                     input logic [9:0] a, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu(0, 0, 10'h0, 32'h0, 3'b000);
    dbg(0, 0, 0, 10'h0, 32'h0);
    #2;
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_gnts", {30'b0, cpu_gnt, dbg_gnt}, 32'd0);
    chk("rst_mem_en_be", {27'b0, mem_en, mem_be}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // SW 0x010
    cpu(1, 1, 10'h010, 32'hDEADBEEF, 3'b010); #1;
    chk("sw_gnt_fault_en", {29'b0, cpu_gnt, cpu_fault, mem_en}, 32'b101);
    chk("sw_be", {28'b0, mem_be}, 32'hF);
    chk("sw_addr", {24'b0, mem_addr}, 32'h004);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    // LW 0x010
    cpu(1, 0, 10'h010, 32'h0, 3'b010); #1;
    chk("lw_gnt_en", {30'b0, cpu_gnt, mem_en}, 32'b11);
    chk("lw_be", {28'b0, mem_be}, 32'h0);
    tick();
    cpu(0, 0, 10'h0, 32'h0, 3'b000); #1;
    chk("lw_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b10);
    chk("lw_rdata", cpu_rdata, 32'hDEADBEEF);

    // debug clears word 4, then SB 0x013 and LBU 0x013
    dbg(1, 1, 0, 10'h013, 32'h00000000); #1;
    chk("dbgw_gnt", {30'b0, cpu_gnt, dbg_gnt}, 32'b01);
    chk("dbgw_be_addr", {20'b0, mem_be, mem_addr}, {20'b0, 4'hF, 8'h04});
    tick();
    dbg(0, 0, 0, 10'h0, 32'h0);
    cpu(1, 1, 10'h013, 32'h000000A5, 3'b000); #1;
    chk("sb_be", {28'b0, mem_be}, 32'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    cpu(1, 0, 10'h013, 32'h0, 3'b100); #1;
    chk("lbu_gnt", {31'b0, cpu_gnt}, 32'd1);
    tick();
    // SH 0x012 issued while the LBU data returns
    cpu(1, 1, 10'h012, 32'h00001234, 3'b001); #1;
    chk("lbu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("lbu_rdata", cpu_rdata, 32'h000000A5);
    chk("sh_be", {28'b0, mem_be}, 32'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    tick();
    cpu(1, 0, 10'h012, 32'h0, 3'b101); #1;
    chk("sh_no_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    tick();
    cpu(0, 0, 10'h0, 32'h0, 3'b000);
    dbg(1, 0, 0, 10'h010, 32'h0); #1;
    chk("lhu_rdata", cpu_rdata, 32'h00001234);
    chk("dbgr_gnt", {30'b0, cpu_gnt, dbg_gnt}, 32'b01);
    tick();

    // both read every cycle: last grant was DBG, so CPU goes first
    prev_cpu  = 1'b0;
    prev_data = 32'h12340000;
    for (int k = 0; k < 6; k++) begin
      cpu(1, 0, 10'h010, 32'h0, 3'b010);
      dbg(1, 0, 0, 10'h000, 32'h0); #1;
      chk($sformatf("alt%0d_gnt", k), {30'b0, cpu_gnt, dbg_gnt},
          (k % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("alt%0d_rvalid", k), {30'b0, cpu_rvalid, dbg_rvalid},
          prev_cpu ? 32'b10 : 32'b01);
      chk($sformatf("alt%0d_rdata", k), prev_cpu ? cpu_rdata : dbg_rdata, prev_data);
      prev_cpu  = (k % 2 == 0);
      prev_data = prev_cpu ? 32'h12340000 : 32'h00000000;
      tick();
    end

    // lock: tie would go to CPU, but only debug may be granted
    dbg(1, 0, 1, 10'h000, 32'h0); #1;
    chk("alt_last_dbg_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b01);
    chk("lock_gnt", {30'b0, cpu_gnt, dbg_gnt}, 32'b01);
    tick();
    dbg(1, 0, 0, 10'h000, 32'h0); #1;
    chk("unlock_gnt", {30'b0, cpu_gnt, dbg_gnt}, 32'b10);
    chk("unlock_dbg_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b01);
    tick();
    // lock rises with the CPU read pending
    dbg(0, 0, 1, 10'h000, 32'h0); #1;
    chk("lock_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    chk("lock_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("lock_cpu_rdata", cpu_rdata, 32'h12340000);
    tick();
    cpu(0, 0, 10'h0, 32'h0, 3'b000);
    dbg(0, 0, 0, 10'h0, 32'h0);
    tick();

    // faults
    cpu(1, 0, 10'h002, 32'h0, 3'b010); #1;
    chk("flw_gnt_fault_en", {29'b0, cpu_gnt, cpu_fault, mem_en}, 32'b110);
    tick();
    cpu(1, 1, 10'h001, 32'h0000FFFF, 3'b001); #1;
    chk("flw_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("flw_rdata", cpu_rdata, 32'h0);
    chk("fsh_gnt_fault_en", {29'b0, cpu_gnt, cpu_fault, mem_en}, 32'b110);
    chk("fsh_be", {28'b0, mem_be}, 32'h0);
    tick();
    cpu(1, 1, 10'h010, 32'h0, 3'b011); #1;
    chk("fst3_fault_en", {30'b0, cpu_fault, mem_en}, 32'b10);
    tick();
    cpu(1, 0, 10'h010, 32'h0, 3'b110); #1;
    chk("fld6_fault_en", {30'b0, cpu_fault, mem_en}, 32'b10);
    cpu(1, 0, 10'h010, 32'h0, 3'b101); #1;
    chk("lhu_ok_fault_en", {30'b0, cpu_fault, mem_en}, 32'b01);
    cpu(0, 0, 10'h0, 32'h0, 3'b000);
    tick();

    // reset with a debug read pending
    dbg(1, 0, 0, 10'h010, 32'h0); #1;
    chk("rstrd_gnt", {31'b0, dbg_gnt}, 32'd1);
    tick();
    dbg(0, 0, 0, 10'h0, 32'h0);
    rst_n = 1'b0; #1;
    chk("rstrd_no_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cpu(1, 0, 10'h010, 32'h0, 3'b010);
    dbg(1, 0, 0, 10'h000, 32'h0); #1;
    chk("post_rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
    chk("post_rst_tie", {30'b0, cpu_gnt, dbg_gnt}, 32'b10);
    tick();
    #1;
    chk("post_rst_tie2", {30'b0, cpu_gnt, dbg_gnt}, 32'b01);
    chk("post_rst_cpu_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b10);
    cpu(0, 0, 10'h0, 32'h0, 3'b000);
    dbg(0, 0, 0, 10'h0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
